// File: rtl/wc_pkg.sv
// Shared constants, FSM state encodings and slot pack/unpack helpers for the
// Winograd tile scheduler, the wc core and the bench.
// Slot 0 of every lane bus sits in the MSBs.
package wc_pkg;

   localparam int W     = 10;           // sample / result lane width
   localparam int N_IN  = 9;            // samples per tile (core D lanes)
   localparam int N_OUT = 7;            // results per tile (core Z lanes)
   localparam int OVL   = N_IN - N_OUT; // samples carried into the next tile
   localparam int LAT   = 6;            // core latency, D stable to Z valid

   typedef logic [1:0] state_t;
   localparam state_t FILL  = 2'd0;
   localparam state_t WAIT  = 2'd1;
   localparam state_t DRAIN = 2'd2;

   function automatic logic [W-1:0] d_get(input logic [N_IN*W-1:0] d, input int i);
      return d[(N_IN-1-i)*W +: W];
   endfunction

   function automatic logic [N_IN*W-1:0] d_put(input logic [N_IN*W-1:0] d, input int i,
                                               input logic [W-1:0] v);
      logic [N_IN*W-1:0] r;
      r = d;
      r[(N_IN-1-i)*W +: W] = v;
      return r;
   endfunction

   function automatic logic [W-1:0] z_get(input logic [N_OUT*W-1:0] z, input int i);
      return z[(N_OUT-1-i)*W +: W];
   endfunction

   function automatic logic [N_OUT*W-1:0] z_put(input logic [N_OUT*W-1:0] z, input int i,
                                               input logic [W-1:0] v);
      logic [N_OUT*W-1:0] r;
      r = z;
      r[(N_OUT-1-i)*W +: W] = v;
      return r;
   endfunction

endpackage

// File: rtl/wc_res_serializer.sv
// Purpose: captures the core's 7 result lanes and emits the first n_res serially.
// Latency: first result valid the cycle after cap; one result per accepted transfer.
// Backpressure: each result is held stable on out_data until out_ready accepts it.
// Ports: cap/z/n_res/last load a tile; out_* is the valid/ready stream; done
//        pulses with the transfer of the final emitted result.
module wc_res_serializer
   import wc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               cap,
   input  logic [N_OUT*W-1:0] z,
   input  logic [2:0]         n_res,
   input  logic               last,
   output logic [W-1:0]       out_data,
   output logic               out_valid,
   output logic               out_last,
   input  logic               out_ready,
   output logic               done
);

   logic [W-1:0] res_q [N_OUT];
   logic [2:0]   idx_q;
   logic [2:0]   n_q;
   logic         last_q;
   logic         vld_q;
   logic         final_slot;

   assign final_slot = (idx_q == n_q - 3'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_OUT; i++) res_q[i] <= '0;
         idx_q  <= '0;
         n_q    <= '0;
         last_q <= 1'b0;
         vld_q  <= 1'b0;
      end else if (cap) begin
         for (int i = 0; i < N_OUT; i++) res_q[i] <= z_get(z, i);
         idx_q  <= '0;
         n_q    <= n_res;
         last_q <= last;
         vld_q  <= 1'b1;
      end else if (vld_q && out_ready) begin
         if (final_slot) vld_q <= 1'b0;
         else            idx_q <= idx_q + 3'd1;
      end
   end

   // Data is forced to zero when idle so nothing stale leaks downstream.
   assign out_valid = vld_q;
   assign out_data  = vld_q ? res_q[idx_q] : '0;
   assign out_last  = vld_q && last_q && final_slot;
   assign done      = vld_q && out_ready && final_slot;

endmodule

// File: rtl/wc_tile_sched.sv
// Purpose: cuts a serial sample row into overlapping 9-sample tiles for wc and serialises its 7 results.
// Latency: first result valid LAT+1 cycles after the accept that completes a tile.
// Backpressure: in_ready drops for WAIT and DRAIN; results hold on out_data until out_ready.
// Ports: in_* sample stream in, wc_d/wc_z core lanes, out_* result stream out,
//        err_short pulses on a discarded row shorter than 3 samples, busy flags work in flight.
// Optional: define WC_TILE_STATS_EN to add tile_cnt, a wrapping count of captured tiles.
module wc_tile_sched
   import wc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [W-1:0]       in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic [N_IN*W-1:0]  wc_d,
   input  logic [N_OUT*W-1:0] wc_z,
   output logic [W-1:0]       out_data,
   output logic               out_valid,
   output logic               out_last,
   input  logic               out_ready,
   output logic               err_short,
`ifdef WC_TILE_STATS_EN
   output logic [15:0]        tile_cnt,
`endif
   output logic               busy
);

   localparam int         LW       = $clog2(LAT + 1);
   localparam logic [3:0] CNT_LAST = 4'(N_IN - 1);
   localparam logic [3:0] CNT_OVL  = 4'(OVL);

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic [W-1:0]  win_q [N_IN];
   logic [LW-1:0] lat_q;
   logic [2:0]    nres_q;
   logic          last_q;
   logic          err_q;
   logic          acc;
   logic          cap;
   logic          done;

   assign in_ready = !rst && (state_q == FILL);
   assign acc      = in_valid && in_ready;
   // Z is taken LAT+1 edges after the final accept, one edge after it settles.
   assign cap      = (state_q == WAIT) && (lat_q == LW'(LAT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         lat_q   <= '0;
         nres_q  <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < N_IN; i++) win_q[i] <= '0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            FILL: begin
               if (acc) begin
                  // Only a fresh row can end below OVL+1 samples; continuation
                  // tiles already hold OVL carried samples.
                  if (in_last && cnt_q < CNT_OVL) begin
                     err_q <= 1'b1;
                     cnt_q <= '0;
                     for (int i = 0; i < N_IN; i++) win_q[i] <= '0;
                  end else begin
                     win_q[cnt_q] <= in_data;
                     cnt_q        <= cnt_q + 4'd1;
                     if (in_last) begin
                        for (int i = 0; i < N_IN; i++)
                           if (4'(i) > cnt_q) win_q[i] <= '0;
                        nres_q  <= 3'(cnt_q - 4'd1);
                        last_q  <= 1'b1;
                        lat_q   <= '0;
                        state_q <= WAIT;
                     end else if (cnt_q == CNT_LAST) begin
                        nres_q  <= 3'(N_OUT);
                        last_q  <= 1'b0;
                        lat_q   <= '0;
                        state_q <= WAIT;
                     end
                  end
               end
            end
            WAIT: begin
               if (cap) state_q <= DRAIN;
               else     lat_q   <= lat_q + LW'(1);
            end
            DRAIN: begin
               if (done) begin
                  if (last_q) begin
                     for (int i = 0; i < N_IN; i++) win_q[i] <= '0;
                     cnt_q <= '0;
                  end else begin
                     // Overlap: the last two samples open the next tile.
                     win_q[0] <= win_q[N_IN-2];
                     win_q[1] <= win_q[N_IN-1];
                     cnt_q    <= CNT_OVL;
                  end
                  state_q <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   always_comb begin
      wc_d = '0;
      for (int i = 0; i < N_IN; i++) wc_d = d_put(wc_d, i, win_q[i]);
   end

   assign err_short = err_q;
   assign busy      = !((state_q == FILL) && (cnt_q == 4'd0));

`ifdef WC_TILE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)      tile_cnt <= '0;
      else if (cap) tile_cnt <= tile_cnt + 16'd1;
   end
`endif

   wc_res_serializer u_ser (
      .clk       (clk),
      .rst       (rst),
      .cap       (cap),
      .z         (wc_z),
      .n_res     (nres_q),
      .last      (last_q),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .done      (done)
   );

endmodule

// File: tb/tb_wc_tile_sched.sv
// Bench for wc_tile_sched: a LAT-deep core model z[i] = d[i] + 2*d[i+1] - d[i+2],
// directed rows with hand-computed results, and a negedge monitor for transfers.
module tb_wc_tile_sched;
   import wc_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [W-1:0]       in_data;
   logic               in_valid;
   logic               in_last;
   logic               in_ready;
   logic [N_IN*W-1:0]  wc_d;
   logic [N_OUT*W-1:0] wc_z;
   logic [W-1:0]       out_data;
   logic               out_valid;
   logic               out_last;
   logic               out_ready;
   logic               err_short;
   logic               busy;
`ifdef WC_TILE_STATS_EN
   logic [15:0]        tile_cnt;
`endif

   int total = 0;
   int bad   = 0;

   wc_tile_sched dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .wc_d      (wc_d),
      .wc_z      (wc_z),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .err_short (err_short),
`ifdef WC_TILE_STATS_EN
      .tile_cnt  (tile_cnt),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Core model
   logic [N_OUT*W-1:0] zp [LAT];

   function automatic logic [N_OUT*W-1:0] core_f(input logic [N_IN*W-1:0] d);
      logic [N_OUT*W-1:0] z;
      logic [W-1:0] a, b, c;
      z = '0;
      for (int i = 0; i < N_OUT; i++) begin
         a = d_get(d, i);
         b = d_get(d, i + 1);
         c = d_get(d, i + 2);
         z = z_put(z, i, a + {b[W-2:0], 1'b0} - c);
      end
      return z;
   endfunction

   always @(posedge clk) begin
      zp[0] <= core_f(wc_d);
      for (int k = 1; k < LAT; k++) zp[k] <= zp[k-1];
   end
   assign wc_z = zp[LAT-1];

   // Monitor
   int unsigned       cyc = 0;
   int unsigned       acc_cyc = 0;
   int unsigned       ov_cyc = 0;
   logic              ov_prev = 1'b0;
   logic              prev_stall = 1'b0;
   logic [W-1:0]      prev_data = '0;
   int                stall_viol = 0;
   int                rdy_viol = 0;
   int                err_cnt = 0;
   int                ovld_cnt = 0;
   logic [W-1:0]      od [$];
   logic              ol [$];
   logic [N_IN*W-1:0] dq [$];
   logic [W-1:0]      stim [32];
   logic              tog_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (in_valid && in_ready) acc_cyc = cyc + 1;
         if (out_valid && !ov_prev) begin
            ov_cyc = cyc;
            dq.push_back(wc_d);
         end
         if (out_valid && in_ready) rdy_viol++;
         if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
         if (out_valid && out_ready) begin
            od.push_back(out_data);
            ol.push_back(out_last);
         end
         if (err_short) err_cnt++;
         if (out_valid) ovld_cnt++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
      ov_prev = out_valid;
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_ready = tog_en ? ~out_ready : 1'b1;
      end
   end

   // Stimulus utilities
   task automatic clear_obs();
      od.delete();
      ol.delete();
      dq.delete();
   endtask

   task automatic drive_row(input int n);
      int g;
      for (int k = 0; k < n; k++) begin
         in_data  = stim[k];
         in_valid = 1'b1;
         in_last  = (k == n - 1);
         g = 0;
         @(negedge clk);
         while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
         end
         if (g >= 300) begin
            total++; bad++;
            $display("FAIL drive_timeout sample=%0d in_ready=%0b required=1", k, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_obs(input int n);
      int g = 0;
      while (od.size() < n && g < 500) begin
         @(negedge clk);
         g++;
      end
      repeat (12) @(negedge clk);
      @(posedge clk); #1;
   endtask

   // Tests
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
      total++; if ({out_valid, out_last, err_short, busy} !== 4'b0) begin bad++;
         $display("FAIL rst_flags got=%b exp=0000", {out_valid, out_last, err_short, busy}); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
      total++; if (wc_d !== '0) begin bad++; $display("FAIL rst_wc_d got=%0h exp=0", wc_d); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%0b exp=1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_single_tile();
      int v[9] = '{2, -10, 3, 4, -13, -18, -16, -28, -11};
      int e[7] = '{-21, -8, 24, -4, -33, -22, -61};
      logic [N_IN*W-1:0] ed;
      ed = {W'(2), W'(-10), W'(3), W'(4), W'(-13), W'(-18), W'(-16), W'(-28), W'(-11)};
      clear_obs();
      for (int k = 0; k < 9; k++) stim[k] = W'(v[k]);
      drive_row(9);
      total++; if (wc_d !== ed) begin bad++; $display("FAIL single_wc_d got=%0h exp=%0h", wc_d, ed); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL single_wait_in_ready got=%0b exp=0", in_ready); end
      wait_obs(7);
      total++; if (od.size() !== 7) begin bad++; $display("FAIL single_count got=%0d exp=7", od.size()); end
      for (int i = 0; i < 7; i++) begin
         if (i < od.size()) begin
            total++; if (od[i] !== W'(e[i]) || ol[i] !== (i == 6)) begin bad++;
               $display("FAIL single_out[%0d] got=%0h/%0b exp=%0h/%0b", i, od[i], ol[i], W'(e[i]), (i == 6)); end
         end
      end
      total++; if (ov_cyc - acc_cyc !== LAT + 1) begin bad++;
         $display("FAIL single_latency got=%0d exp=%0d", ov_cyc - acc_cyc, LAT + 1); end
   endtask

   task automatic test_row16();
      logic [N_IN*W-1:0] e1, e2;
      e1 = {W'(1), W'(2), W'(3), W'(4), W'(5), W'(6), W'(7), W'(8), W'(9)};
      e2 = {W'(8), W'(9), W'(10), W'(11), W'(12), W'(13), W'(14), W'(15), W'(16)};
      clear_obs();
      for (int k = 0; k < 16; k++) stim[k] = W'(k + 1);
      drive_row(16);
      wait_obs(14);
      total++; if (od.size() !== 14) begin bad++; $display("FAIL row16_count got=%0d exp=14", od.size()); end
      for (int i = 0; i < 14; i++) begin
         if (i < od.size()) begin
            total++; if (od[i] !== W'(2 * (i + 1)) || ol[i] !== (i == 13)) begin bad++;
               $display("FAIL row16_out[%0d] got=%0d/%0b exp=%0d/%0b", i, od[i], ol[i], 2 * (i + 1), (i == 13)); end
         end
      end
      total++; if (dq.size() !== 2) begin bad++; $display("FAIL row16_tiles got=%0d exp=2", dq.size()); end
      if (dq.size() >= 2) begin
         total++; if (dq[0] !== e1) begin bad++; $display("FAIL row16_tile1 got=%0h exp=%0h", dq[0], e1); end
         total++; if (dq[1] !== e2) begin bad++; $display("FAIL row16_tile2 got=%0h exp=%0h", dq[1], e2); end
      end
   endtask

   task automatic test_row12();
      logic [N_IN*W-1:0] e2;
      e2 = {W'(8), W'(9), W'(10), W'(11), W'(12), W'(0), W'(0), W'(0), W'(0)};
      clear_obs();
      for (int k = 0; k < 12; k++) stim[k] = W'(k + 1);
      drive_row(12);
      wait_obs(10);
      total++; if (od.size() !== 10) begin bad++; $display("FAIL row12_count got=%0d exp=10", od.size()); end
      for (int i = 0; i < 10; i++) begin
         if (i < od.size()) begin
            total++; if (od[i] !== W'(2 * (i + 1)) || ol[i] !== (i == 9)) begin bad++;
               $display("FAIL row12_out[%0d] got=%0d/%0b exp=%0d/%0b", i, od[i], ol[i], 2 * (i + 1), (i == 9)); end
         end
      end
      if (dq.size() >= 2) begin
         total++; if (dq[1] !== e2) begin bad++; $display("FAIL row12_tile2 got=%0h exp=%0h", dq[1], e2); end
      end else begin
         total++; bad++; $display("FAIL row12_tiles got=%0d exp=2", dq.size());
      end
   endtask

   task automatic test_stall();
      clear_obs();
      stall_viol = 0;
      rdy_viol   = 0;
      for (int k = 0; k < 9; k++) stim[k] = W'(10 * (k + 1));
      tog_en = 1'b1;
      drive_row(9);
      wait_obs(7);
      tog_en = 1'b0;
      total++; if (od.size() !== 7) begin bad++; $display("FAIL stall_count got=%0d exp=7", od.size()); end
      for (int i = 0; i < 7; i++) begin
         if (i < od.size()) begin
            total++; if (od[i] !== W'(20 * (i + 1)) || ol[i] !== (i == 6)) begin bad++;
               $display("FAIL stall_out[%0d] got=%0d/%0b exp=%0d/%0b", i, od[i], ol[i], 20 * (i + 1), (i == 6)); end
         end
      end
      total++; if (stall_viol !== 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", stall_viol); end
      total++; if (rdy_viol !== 0) begin bad++; $display("FAIL stall_in_ready got=%0d exp=0", rdy_viol); end
   endtask

   task automatic test_short_row();
      int e0, v0;
      clear_obs();
      e0 = err_cnt;
      v0 = ovld_cnt;
      stim[0] = W'(5);
      stim[1] = W'(6);
      drive_row(2);
      repeat (12) @(posedge clk);
      #1;
      total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL short_err got=%0d exp=1", err_cnt - e0); end
      total++; if (ovld_cnt !== v0) begin bad++; $display("FAIL short_no_out got=%0d exp=%0d", ovld_cnt, v0); end
      total++; if (busy !== 1'b0 || wc_d !== '0) begin bad++;
         $display("FAIL short_cleared got=%0b/%0h exp=0/0", busy, wc_d); end
      for (int k = 0; k < 9; k++) stim[k] = W'(k + 1);
      drive_row(9);
      wait_obs(7);
      total++; if (od.size() !== 7) begin bad++; $display("FAIL short_next_count got=%0d exp=7", od.size()); end
      for (int i = 0; i < 7; i++) begin
         if (i < od.size()) begin
            total++; if (od[i] !== W'(2 * (i + 1)) || ol[i] !== (i == 6)) begin bad++;
               $display("FAIL short_next_out[%0d] got=%0d/%0b exp=%0d/%0b", i, od[i], ol[i], 2 * (i + 1), (i == 6)); end
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      clear_obs();
      for (int k = 0; k < 9; k++) stim[k] = W'(100 + k);
      drive_row(9);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if ({out_valid, out_last, err_short, busy, in_ready} !== 5'b0) begin bad++;
         $display("FAIL midrst_flags got=%b exp=00000", {out_valid, out_last, err_short, busy, in_ready}); end
      total++; if (out_data !== '0 || wc_d !== '0) begin bad++;
         $display("FAIL midrst_data got=%0h/%0h exp=0/0", out_data, wc_d); end
      rst = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      total++; if (od.size() !== 0) begin bad++; $display("FAIL midrst_no_out got=%0d exp=0", od.size()); end
      drive_row(9);
      wait_obs(7);
      total++; if (od.size() !== 7) begin bad++; $display("FAIL midrst_count got=%0d exp=7", od.size()); end
      for (int i = 0; i < 7; i++) begin
         if (i < od.size()) begin
            total++; if (od[i] !== W'(200 + 2 * i) || ol[i] !== (i == 6)) begin bad++;
               $display("FAIL midrst_out[%0d] got=%0d/%0b exp=%0d/%0b", i, od[i], ol[i], 200 + 2 * i, (i == 6)); end
         end
      end
`ifdef WC_TILE_STATS_EN
      total++; if (tile_cnt !== 16'd1) begin bad++; $display("FAIL midrst_tile_cnt got=%0d exp=1", tile_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_row16();
      test_row12();
      test_stall();
      test_short_row();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog cycles=%0d limit reached", cyc);
      $fatal(1, "watchdog");
   end

endmodule
